// File: rtl/mem_writer_if.sv
// Stream-in / memory-out bundle for mem_writer.
// The slave modport is the writer's view; the master modport is the producer/memory side.
interface mem_writer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   count;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              mem_enable;
  logic              mem_read_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              done;
  logic              error;

  modport slave (
    input  start, base_addr, count, in_valid, in_data, mem_rdata,
    output in_ready, mem_enable, mem_read_write, mem_addr, mem_wdata,
    output busy, done, error
  );

  modport master (
    output start, base_addr, count, in_valid, in_data, mem_rdata,
    input  in_ready, mem_enable, mem_read_write, mem_addr, mem_wdata,
    input  busy, done, error
  );
endinterface

// File: rtl/mem_writer.sv
// Writes a run of streamed words to consecutive addresses of the 8x16 memory.
// Define MEM_WRITER_VERIFY_EN to read back and compare every written word.
module mem_writer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input logic          clk,
  input logic          reset,
  mem_writer_if.slave  bus
);

  localparam logic [ADDR_W:0]   MAX_COUNT = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [ADDR_W:0]   ONE_CNT   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    WRITE,
`ifdef MEM_WRITER_VERIFY_EN
    VERIFY,
`endif
    DONE
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addrPtr;
  logic [ADDR_W:0]   r_remaining;
  logic              r_inReady;
  logic              r_memEnable;
  logic [ADDR_W-1:0] r_memAddr;
  logic [DATA_W-1:0] r_memWdata;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W:0]   w_countSat;
`ifdef MEM_WRITER_VERIFY_EN
  logic              r_memReadWrite;
  logic              r_error;
`endif

  assign w_countSat = (bus.count > MAX_COUNT) ? MAX_COUNT : bus.count;

  // r_memAddr holds the address of the current write so VERIFY reads the same
  // location while r_addrPtr has already moved on to the next one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_addrPtr   <= '0;
      r_remaining <= '0;
      r_inReady   <= 1'b0;
      r_memEnable <= 1'b0;
      r_memAddr   <= '0;
      r_memWdata  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef MEM_WRITER_VERIFY_EN
      r_memReadWrite <= 1'b0;
      r_error        <= 1'b0;
`endif
    end else begin
      r_done      <= 1'b0;
      r_memEnable <= 1'b0;
`ifdef MEM_WRITER_VERIFY_EN
      r_memReadWrite <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_addrPtr   <= bus.base_addr;
            r_remaining <= w_countSat;
            r_busy      <= 1'b1;
`ifdef MEM_WRITER_VERIFY_EN
            r_error     <= 1'b0;
`endif
            if (w_countSat == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state   <= WAIT_DATA;
              r_inReady <= 1'b1;
            end
          end
        end
        WAIT_DATA: begin
          if (bus.in_valid && r_inReady) begin
            r_memWdata  <= bus.in_data;
            r_memAddr   <= r_addrPtr;
            r_memEnable <= 1'b1;
            r_inReady   <= 1'b0;
            r_state     <= WRITE;
          end
        end
        WRITE: begin
          r_remaining <= r_remaining - ONE_CNT;
          r_addrPtr   <= r_addrPtr + ONE_ADDR;
`ifdef MEM_WRITER_VERIFY_EN
          r_memEnable    <= 1'b1;
          r_memReadWrite <= 1'b1;
          r_state        <= VERIFY;
`else
          if (r_remaining == ONE_CNT) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_state   <= WAIT_DATA;
            r_inReady <= 1'b1;
          end
`endif
        end
`ifdef MEM_WRITER_VERIFY_EN
        VERIFY: begin
          if (bus.mem_rdata != r_memWdata) r_error <= 1'b1;
          if (r_remaining == '0) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_state   <= WAIT_DATA;
            r_inReady <= 1'b1;
          end
        end
`endif
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state   <= IDLE;
          r_busy    <= 1'b0;
          r_inReady <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = r_inReady;
  assign bus.mem_enable = r_memEnable;
  assign bus.mem_addr   = r_memAddr;
  assign bus.mem_wdata  = r_memWdata;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

`ifdef MEM_WRITER_VERIFY_EN
  assign bus.mem_read_write = r_memReadWrite;
  assign bus.error          = r_error;
`else
  logic w_unusedRdata;
  assign w_unusedRdata      = ^bus.mem_rdata;
  assign bus.mem_read_write = 1'b0;
  assign bus.error          = 1'b0;
`endif

endmodule

// File: tb/tb_mem_writer.sv
// Directed bench for mem_writer with a small behavioural memory model.
// Builds with or without MEM_WRITER_VERIFY_EN.
module tb_mem_writer;

`ifdef MEM_WRITER_VERIFY_EN
  localparam int EXP_LAT8 = 25;
`else
  localparam int EXP_LAT8 = 17;
`endif

  logic clk;
  logic reset;
  logic forceDead;
  logic [15:0] mem [8];
  logic [15:0] words [8];
  logic [15:0] expMem [8];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int writeCount = 0;
  int doneCount = 0;
  int backToBack = 0;
  int badWrite = 0;
  int startCyc = 0;
  int doneCyc = 0;
  int writeSnap, doneSnap, b2bSnap, badSnap;
  logic prevWrite = 1'b0;
  logic prevHs = 1'b0;

  mem_writer_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  mem_writer #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: synchronous write, asynchronous read, optional stuck word at address 2
  always @(posedge clk) begin
    if (bus.mem_enable && !bus.mem_read_write) mem[bus.mem_addr] <= bus.mem_wdata;
  end
  assign bus.mem_rdata = (forceDead && bus.mem_addr == 3'd2) ? 16'hDEAD : mem[bus.mem_addr];

  // Bus monitor: counts write pulses and done pulses, flags writes without a preceding handshake
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset) begin
      if (bus.mem_enable && !bus.mem_read_write) begin
        writeCount <= writeCount + 1;
        if (prevWrite) backToBack <= backToBack + 1;
        if (!prevHs) badWrite <= badWrite + 1;
      end
      if (bus.done) begin
        doneCount <= doneCount + 1;
        doneCyc   <= cyc;
      end
      if (bus.start && !bus.busy) startCyc <= cyc;
    end
    prevWrite <= bus.mem_enable && !bus.mem_read_write;
    prevHs    <= bus.in_valid && bus.in_ready;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_inReady"}, 32'(bus.in_ready), 0);
    checkOutput({tag, "_memEnable"}, 32'(bus.mem_enable), 0);
    checkOutput({tag, "_readWrite"}, 32'(bus.mem_read_write), 0);
    checkOutput({tag, "_memAddr"}, 32'(bus.mem_addr), 0);
    checkOutput({tag, "_memWdata"}, 32'(bus.mem_wdata), 0);
    checkOutput({tag, "_busy"}, 32'(bus.busy), 0);
    checkOutput({tag, "_done"}, 32'(bus.done), 0);
    checkOutput({tag, "_error"}, 32'(bus.error), 0);
  endtask

  task automatic checkMemory(input string tag);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("%s_mem%0d", tag, i), 32'(mem[i]), 32'(expMem[i]));
  endtask

  // Starts a run and feeds words[] until nWords are accepted or the guard expires
  task automatic applyStimulus(input logic [2:0] base, input logic [3:0] cnt, input int nWords,
                               input bit randValid, input bit restartMid, input int abortAfter);
    int idx = 0;
    int guard = 0;
    bit hs;
    @(negedge clk);
    writeSnap = writeCount;
    doneSnap  = doneCount;
    b2bSnap   = backToBack;
    badSnap   = badWrite;
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.count     = cnt;
    @(negedge clk);
    bus.start = 1'b0;
    while (idx < nWords && guard < 400) begin
      if (abortAfter > 0 && (writeCount - writeSnap) >= abortAfter) break;
      bus.in_valid = randValid ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_data  = words[idx];
      if (restartMid && guard == 2) begin
        bus.start     = 1'b1;
        bus.base_addr = 3'd0;
        bus.count     = 4'd0;
      end else begin
        bus.start = 1'b0;
      end
      hs = bus.in_valid && bus.in_ready;
      @(negedge clk);
      if (hs) idx++;
      guard++;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int maxCycles);
    int k = 0;
    while (doneCount == doneSnap && k < maxCycles) begin
      @(negedge clk);
      k++;
    end
    checkOutput({tag, "_donePulses"}, 32'(doneCount - doneSnap), 1);
  endtask

  initial begin
    forceDead     = 1'b0;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.count     = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    reset = 1'b0;

    // Basic run: base 0, eight words, valid held high
    for (int i = 0; i < 8; i++) words[i] = 16'(16'h1000 + i);
    applyStimulus(3'd0, 4'd8, 8, 1'b0, 1'b0, 0);
    waitDone("basic", 60);
    checkOutput("basic_latency", 32'(doneCyc - startCyc), 32'(EXP_LAT8));
    checkOutput("basic_writes", 32'(writeCount - writeSnap), 8);
    checkOutput("basic_backToBack", 32'(backToBack - b2bSnap), 0);
    checkOutput("basic_busyAfter", 32'(bus.busy), 0);
    checkOutput("basic_error", 32'(bus.error), 0);
    for (int i = 0; i < 8; i++) expMem[i] = 16'(16'h1000 + i);
    checkMemory("basic");

    // Wrap-around: base 6, four words land at 6,7,0,1
    words[0] = 16'hA0A0; words[1] = 16'hB1B1; words[2] = 16'hC2C2; words[3] = 16'hD3D3;
    applyStimulus(3'd6, 4'd4, 4, 1'b0, 1'b0, 0);
    waitDone("wrap", 60);
    checkOutput("wrap_writes", 32'(writeCount - writeSnap), 4);
    expMem[6] = 16'hA0A0; expMem[7] = 16'hB1B1; expMem[0] = 16'hC2C2; expMem[1] = 16'hD3D3;
    checkMemory("wrap");

    // Backpressure: random in_valid, base 3, five words
    for (int i = 0; i < 5; i++) words[i] = 16'(16'h3300 + i);
    applyStimulus(3'd3, 4'd5, 5, 1'b1, 1'b0, 0);
    waitDone("bp", 200);
    checkOutput("bp_writes", 32'(writeCount - writeSnap), 5);
    checkOutput("bp_writeWithoutHandshake", 32'(badWrite - badSnap), 0);
    for (int i = 0; i < 5; i++) expMem[3 + i] = 16'(16'h3300 + i);
    checkMemory("bp");

    // Zero-length run: done one cycle after start, no memory access
    applyStimulus(3'd5, 4'd0, 0, 1'b0, 1'b0, 0);
    waitDone("zero", 10);
    checkOutput("zero_latency", 32'(doneCyc - startCyc), 1);
    checkOutput("zero_writes", 32'(writeCount - writeSnap), 0);

    // Second start while busy must be ignored
    words[0] = 16'h4400; words[1] = 16'h4401;
    applyStimulus(3'd4, 4'd2, 2, 1'b0, 1'b1, 0);
    waitDone("restart", 40);
    repeat (3) @(negedge clk);
    checkOutput("restart_donePulsesLater", 32'(doneCount - doneSnap), 1);
    checkOutput("restart_writes", 32'(writeCount - writeSnap), 2);
    expMem[4] = 16'h4400; expMem[5] = 16'h4401;
    checkMemory("restart");

    // Oversized count saturates to eight words starting at base 5
    for (int i = 0; i < 8; i++) words[i] = 16'(16'h5500 + i);
    applyStimulus(3'd5, 4'd15, 8, 1'b0, 1'b0, 0);
    waitDone("sat", 80);
    checkOutput("sat_writes", 32'(writeCount - writeSnap), 8);
    for (int i = 0; i < 8; i++) expMem[(5 + i) % 8] = 16'(16'h5500 + i);
    checkMemory("sat");

    // Reset after the third write of an eight-word run
    for (int i = 0; i < 8; i++) words[i] = 16'(16'h2000 + i);
    applyStimulus(3'd0, 4'd8, 8, 1'b0, 1'b0, 3);
    checkOutput("midReset_writesBefore", 32'(writeCount - writeSnap), 3);
    reset = 1'b1;
    @(negedge clk);
    checkResetOutputs("midReset");
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("midReset_noDone", 32'(doneCount - doneSnap), 0);
    checkOutput("midReset_busy", 32'(bus.busy), 0);
    for (int i = 0; i < 3; i++) expMem[i] = 16'(16'h2000 + i);
    checkMemory("midReset");

`ifdef MEM_WRITER_VERIFY_EN
    // Readback mismatch on address 2 sets a sticky error until the next start
    forceDead = 1'b1;
    for (int i = 0; i < 4; i++) words[i] = 16'(16'h6000 + i);
    applyStimulus(3'd0, 4'd4, 4, 1'b0, 1'b0, 0);
    waitDone("verify", 60);
    checkOutput("verify_errorSet", 32'(bus.error), 1);
    repeat (3) @(negedge clk);
    checkOutput("verify_errorSticky", 32'(bus.error), 1);
    forceDead = 1'b0;
    applyStimulus(3'd0, 4'd0, 0, 1'b0, 1'b0, 0);
    waitDone("verifyClear", 10);
    checkOutput("verify_errorCleared", 32'(bus.error), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
